// File: rtl/usb_pkg.sv
// usb_pkg: line states, framing constants and FSM states shared by the USB transmit path
package usb_pkg;
   localparam logic [1:0] LINE_J       = 2'b10;
   localparam logic [1:0] LINE_K       = 2'b01;
   localparam logic [1:0] LINE_SE0     = 2'b00;
   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam logic [2:0] STUFF_LIMIT  = 3'd6;
   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
endpackage

// File: rtl/usb_nrzi_stuffer.sv
// usb_nrzi_stuffer: NRZI encoder with bit stuffing; consumes one raw bit per strobe unless a stuffed bit is due
module usb_nrzi_stuffer
   import usb_pkg::*;
(
   input  logic clk48,
   input  logic reset_n,
   input  logic i_init,
   input  logic i_strobe,
   input  logic i_valid,
   input  logic i_bit,
   output logic o_ready,
   output logic o_j
);
   logic       r_j;
   logic [2:0] r_ones;
   logic       w_j;
   logic [2:0] w_ones;
   // init restarts the encoder from J with no ones counted, so the first strobe encodes from a clean line
   always_comb begin
      w_j     = i_init ? 1'b1 : r_j;
      w_ones  = i_init ? 3'd0 : r_ones;
      o_ready = w_ones != STUFF_LIMIT;
   end
   // on each bit boundary emit a stuffed transition if due, otherwise encode the offered raw bit
   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         r_j    <= 1'b1;
         r_ones <= 3'd0;
      end else if (i_strobe) begin
         r_j    <= (!o_ready || (i_valid && !i_bit)) ? !w_j : w_j;
         r_ones <= (!o_ready || (i_valid && !i_bit)) ? 3'd0 : (i_valid ? w_ones + 3'd1 : w_ones);
      end
   end
   assign o_j = r_j;
endmodule

// File: rtl/usb_packet_transmitter.sv
// usb_packet_transmitter: frames a buffered packet as SYNC, NRZI/stuffed data and EOP on D+/D-
module usb_packet_transmitter
   import usb_pkg::*;
#(
   parameter int BUFFER_SIZE    = 1024,
   parameter int CLOCKS_PER_BIT = 4
)(
   input  logic                              clk48,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic [$clog2(BUFFER_SIZE):0]      length,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(BUFFER_SIZE/4)-1:0]  buffer_address,
   input  logic [31:0]                       buffer_read_value,
   output logic                              usb_d_p_out,
   output logic                              usb_d_n_out,
   output logic                              usb_output_enable
);
   localparam int LW = $clog2(BUFFER_SIZE) + 1;
   localparam int AW = $clog2(BUFFER_SIZE/4);
   localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [LW-1:0]   r_idx, r_len, w_nidx;
   logic [AW-1:0]   r_addr;
   logic [31:0]     r_word;
   logic            r_done;
   logic            w_accept, w_tick, w_stb, w_valid, w_bit, w_take, w_ready, w_j;
   logic [1:0]      w_line;

   usb_nrzi_stuffer u_stuffer (
      .clk48    (clk48),
      .reset_n  (reset_n),
      .i_init   (w_accept),
      .i_strobe (w_stb),
      .i_valid  (w_valid),
      .i_bit    (w_bit),
      .o_ready  (w_ready),
      .o_j      (w_j)
   );

   // state register
   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // bit strobes, raw bit selection, next state and line mux
   always_comb begin
      w_accept = (r_state == IDLE) && start;
      w_tick   = (r_state != IDLE) && (r_cnt == CW'(CLOCKS_PER_BIT - 1));
      w_stb    = w_accept || (w_tick && (r_state == SYNC || r_state == DATA));
      w_valid  = (r_state == DATA) ? (r_idx < r_len) : 1'b1;
      w_bit    = (r_state == DATA) ? r_word[{r_idx[1:0], r_bit}] :
                 (r_state == IDLE) ? 1'b0 : SYNC_PATTERN[r_bit];
      w_take   = w_stb && w_ready && w_valid;
      w_nidx   = r_idx + LW'(1);
      w_next   = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? SYNC : IDLE;
         SYNC:    w_next = (w_take && r_bit == 3'd7) ? DATA : SYNC;
         DATA:    w_next = (w_stb && w_ready && !w_valid) ? EOP_SE0 : DATA;
         EOP_SE0: w_next = (w_tick && r_bit == 3'd1) ? EOP_J : EOP_SE0;
         EOP_J:   w_next = w_tick ? IDLE : EOP_J;
         default: w_next = IDLE;
      endcase
      w_line   = (r_state == SYNC || r_state == DATA) ? (w_j ? LINE_J : LINE_K) :
                 (r_state == EOP_SE0) ? LINE_SE0 : LINE_J;
   end

   // bit timer, byte/bit pointers, buffer address and word capture
   always_ff @(posedge clk48 or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_bit  <= 3'd0;
         r_idx  <= '0;
         r_len  <= '0;
         r_addr <= '0;
         r_word <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == EOP_J) && w_tick;
         r_word <= buffer_read_value;
         r_cnt  <= (r_state == IDLE || w_tick) ? '0 : r_cnt + CW'(1);
         if (w_accept) begin
            r_len  <= (length > LW'(BUFFER_SIZE)) ? LW'(BUFFER_SIZE) : length;
            r_idx  <= '0;
            r_addr <= '0;
            r_bit  <= 3'd1;
         end else if (w_take) begin
            r_bit <= r_bit + 3'd1;
            if (r_state == DATA && r_bit == 3'd7) begin
               r_idx <= w_nidx;
               if (w_nidx < r_len) r_addr <= AW'(w_nidx >> 2);
            end
         end else if (r_state == EOP_SE0 && w_tick) begin
            r_bit <= (r_bit == 3'd1) ? 3'd0 : 3'd1;
         end
      end
   end

   assign busy              = r_state != IDLE;
   assign usb_output_enable = r_state != IDLE;
   assign done              = r_done;
   assign buffer_address    = r_addr;
   assign {usb_d_p_out, usb_d_n_out} = w_line;
endmodule
